// File: rtl/turbo_iter_ctrl_pkg.sv
// Shared decoder-control definitions: FSM state encoding and default frame geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package turbo_iter_ctrl_pkg;

    // Default number of full turbo iterations (one DEC1 pass plus one DEC2 pass each).
    localparam int TIC_MAX_ITER_DEF  = 8;
    // Default number of input beats that make up one frame.
    localparam int TIC_BLK_BEATS_DEF = 4;

    // Width of the iteration counter and of the beat index.
    localparam int TIC_ITER_W = 6;
    localparam int TIC_BEAT_W = 2;

    // Iteration controller states.
    typedef enum logic [2:0] {
        TIC_IDLE     = 3'd0,
        TIC_LOAD     = 3'd1,
        TIC_D1_ISSUE = 3'd2,
        TIC_D1_WAIT  = 3'd3,
        TIC_D2_ISSUE = 3'd4,
        TIC_D2_WAIT  = 3'd5,
        TIC_FINISH   = 3'd6
    } tic_state_t;

    // True for the two states that belong to the second (interleaved) half-iteration.
    function automatic logic tic_is_dec2(input tic_state_t s);
        return (s == TIC_D2_ISSUE) || (s == TIC_D2_WAIT);
    endfunction

endpackage : turbo_iter_ctrl_pkg

// File: rtl/turbo_iter_ctrl.sv
// Turbo decoder iteration controller: loads a frame, alternates DEC1/DEC2 SISO passes, counts iterations.
// Latency: first siso_start_o 1+BLK_BEATS cycles after start_i with continuous beats; done_o one cycle after the final DEC2 completion.
// Backpressure: LOAD stalls on beat_valid_i gaps, WAIT states hold until siso_done_i, start_i ignored while busy.
//
// Optional feature: define EARLY_STOP_EN to finish after a DEC2 pass whose hard decisions
// did not change (hard_eq_i) once at least one full iteration has completed.
//
// Ports:
//   clk_p_i        clock, all state changes on the rising edge
//   reset_n_i      asynchronous active-low reset
//   start_i        frame start request, sampled only in IDLE
//   beat_valid_i   one input beat available to load
//   load_we_o      write enable to the systematic/parity buffers
//   load_idx_o     beat index for the current write
//   ext_clr_o      one-cycle pulse clearing the extrinsic store at frame start
//   siso_start_o   one-cycle SISO read-enable pulse per half-iteration
//   siso_done_i    SISO completion pulse
//   half_o         0 = DEC1 (natural order, parity 1), 1 = DEC2 (interleaved, parity 2)
//   iter_o         completed full iterations
//   hard_eq_i      hard decisions unchanged since the previous DEC2
//   busy_o         high in every state except IDLE
//   done_o         one-cycle frame-finished pulse
module turbo_iter_ctrl
    import turbo_iter_ctrl_pkg::*;
#(
    parameter int MAX_ITER  = TIC_MAX_ITER_DEF,
    parameter int BLK_BEATS = TIC_BLK_BEATS_DEF
) (
    input  logic                  clk_p_i,
    input  logic                  reset_n_i,
    input  logic                  start_i,
    input  logic                  beat_valid_i,
    output logic                  load_we_o,
    output logic [TIC_BEAT_W-1:0] load_idx_o,
    output logic                  ext_clr_o,
    output logic                  siso_start_o,
    input  logic                  siso_done_i,
    output logic                  half_o,
    output logic [TIC_ITER_W-1:0] iter_o,
    input  logic                  hard_eq_i,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [TIC_BEAT_W-1:0] LAST_BEAT = TIC_BEAT_W'(BLK_BEATS - 1);
    localparam logic [TIC_ITER_W-1:0] ITER_TGT  = TIC_ITER_W'(MAX_ITER);

    tic_state_t            r_state;
    tic_state_t            w_state_nxt;
    logic [TIC_BEAT_W-1:0] r_beat;
    logic [TIC_BEAT_W-1:0] w_beat_nxt;
    logic [TIC_ITER_W-1:0] r_iter;
    logic [TIC_ITER_W-1:0] w_iter_nxt;
    logic [TIC_ITER_W-1:0] w_iter_inc;

    logic w_ext_clr;
    logic w_load_we;
    logic w_siso_start;
    logic w_half;
    logic w_busy;
    logic w_done;
    logic w_early_stop;

    assign w_iter_inc = r_iter + TIC_ITER_W'(1);

`ifdef EARLY_STOP_EN
    // Converged decisions only count once a full iteration has already been
    // completed, so a frame always gets at least two full iterations.
    assign w_early_stop = hard_eq_i && (r_iter >= TIC_ITER_W'(1));
`else
    logic w_unused_hard_eq;
    assign w_unused_hard_eq = hard_eq_i;
    assign w_early_stop     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State, beat count and iteration count registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= TIC_IDLE;
            r_beat  <= '0;
            r_iter  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            r_iter  <= w_iter_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_beat_nxt   = r_beat;
        w_iter_nxt   = r_iter;
        w_ext_clr    = 1'b0;
        w_load_we    = 1'b0;
        w_siso_start = 1'b0;
        w_half       = tic_is_dec2(r_state);
        w_busy       = 1'b1;
        w_done       = 1'b0;

        unique case (r_state)
            TIC_IDLE: begin
                w_busy = 1'b0;
                if (start_i) begin
                    // Fresh frame: wipe extrinsic info and both counters.
                    w_ext_clr   = 1'b1;
                    w_beat_nxt  = '0;
                    w_iter_nxt  = '0;
                    w_state_nxt = TIC_LOAD;
                end
            end

            TIC_LOAD: begin
                if (beat_valid_i) begin
                    w_load_we  = 1'b1;
                    w_beat_nxt = r_beat + TIC_BEAT_W'(1);
                    if (r_beat == LAST_BEAT) begin
                        w_state_nxt = TIC_D1_ISSUE;
                    end
                end
            end

            TIC_D1_ISSUE: begin
                w_siso_start = 1'b1;
                w_state_nxt  = TIC_D1_WAIT;
            end

            TIC_D1_WAIT: begin
                if (siso_done_i) begin
                    w_state_nxt = TIC_D2_ISSUE;
                end
            end

            TIC_D2_ISSUE: begin
                w_siso_start = 1'b1;
                w_state_nxt  = TIC_D2_WAIT;
            end

            TIC_D2_WAIT: begin
                if (siso_done_i) begin
                    // A DEC2 completion closes one full iteration.
                    w_iter_nxt = w_iter_inc;
                    if ((w_iter_inc == ITER_TGT) || w_early_stop) begin
                        w_state_nxt = TIC_FINISH;
                    end else begin
                        w_state_nxt = TIC_D1_ISSUE;
                    end
                end
            end

            TIC_FINISH: begin
                w_done      = 1'b1;
                w_state_nxt = TIC_IDLE;
            end

            default: begin
                w_busy      = 1'b0;
                w_state_nxt = TIC_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // ext_clr_o is decoded from start_i in IDLE, which is also the reset
    // state, so it needs the reset term to stay quiet while reset is held.
    assign ext_clr_o    = w_ext_clr & reset_n_i;
    assign load_we_o    = w_load_we;
    assign load_idx_o   = r_beat;
    assign siso_start_o = w_siso_start;
    assign half_o       = w_half;
    assign iter_o       = r_iter;
    assign busy_o       = w_busy;
    assign done_o       = w_done;

endmodule : turbo_iter_ctrl

// File: tb/tb_turbo_iter_ctrl.sv
// Testbench for turbo_iter_ctrl: three instances (MAX_ITER 1, 2, 8) share one stimulus stream.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_turbo_iter_ctrl;
    import turbo_iter_ctrl_pkg::*;

`ifdef EARLY_STOP_EN
    localparam bit ES = 1'b1;
`else
    localparam bit ES = 1'b0;
`endif

    localparam int NDUT    = 3;
    localparam int P_IDLE  = 0;
    localparam int P_LOAD  = 1;
    localparam int P_ISSUE = 2;
    localparam int P_WAIT  = 3;
    localparam int P_FIN   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic bv    = 1'b0;
    logic sdone = 1'b0;
    logic heq   = 1'b0;

    logic [NDUT-1:0] we, clr, ss, half, busy, dn;
    logic [1:0]      idx  [NDUT];
    logic [5:0]      iter [NDUT];

    always #5 clk = ~clk;

    turbo_iter_ctrl #(.MAX_ITER(1), .BLK_BEATS(4)) u_m1 (
        .clk_p_i(clk), .reset_n_i(rst_n), .start_i(start), .beat_valid_i(bv),
        .load_we_o(we[0]), .load_idx_o(idx[0]), .ext_clr_o(clr[0]), .siso_start_o(ss[0]),
        .siso_done_i(sdone), .half_o(half[0]), .iter_o(iter[0]), .hard_eq_i(heq),
        .busy_o(busy[0]), .done_o(dn[0]));
    turbo_iter_ctrl #(.MAX_ITER(2), .BLK_BEATS(4)) u_m2 (
        .clk_p_i(clk), .reset_n_i(rst_n), .start_i(start), .beat_valid_i(bv),
        .load_we_o(we[1]), .load_idx_o(idx[1]), .ext_clr_o(clr[1]), .siso_start_o(ss[1]),
        .siso_done_i(sdone), .half_o(half[1]), .iter_o(iter[1]), .hard_eq_i(heq),
        .busy_o(busy[1]), .done_o(dn[1]));
    turbo_iter_ctrl #(.MAX_ITER(8), .BLK_BEATS(4)) u_m8 (
        .clk_p_i(clk), .reset_n_i(rst_n), .start_i(start), .beat_valid_i(bv),
        .load_we_o(we[2]), .load_idx_o(idx[2]), .ext_clr_o(clr[2]), .siso_start_o(ss[2]),
        .siso_done_i(sdone), .half_o(half[2]), .iter_o(iter[2]), .hard_eq_i(heq),
        .busy_o(busy[2]), .done_o(dn[2]));

    // ---------------- checking bookkeeping ----------------
    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    task automatic check(input string name, input int got, input int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
    endtask

    function automatic int maxv(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 8);
    endfunction

    // ---------------- behavioural reference model ----------------
    // Frame progress is tracked as: phase, beats accepted, SISO half-passes completed.
    int m_ph     [NDUT];
    int m_beats  [NDUT];
    int m_halves [NDUT];

    task automatic model_reset();
        for (int i = 0; i < NDUT; i++) begin
            m_ph[i] = P_IDLE; m_beats[i] = 0; m_halves[i] = 0;
        end
    endtask

    // Output bit order: {busy, we, idx[1:0], clr, ss, half, iter[5:0], done}
    function automatic logic [13:0] model_out(input int i);
        logic       b_e, w_e, c_e, s_e, h_e, d_e;
        logic [1:0] x_e;
        logic [5:0] t_e;
        b_e = (m_ph[i] != P_IDLE);
        w_e = (m_ph[i] == P_LOAD) && bv;
        x_e = 2'(m_beats[i] % 4);
        c_e = rst_n && (m_ph[i] == P_IDLE) && start;
        s_e = (m_ph[i] == P_ISSUE);
        h_e = ((m_ph[i] == P_ISSUE) || (m_ph[i] == P_WAIT)) && (m_halves[i] % 2 == 1);
        t_e = 6'(m_halves[i] / 2);
        d_e = (m_ph[i] == P_FIN);
        return {b_e, w_e, x_e, c_e, s_e, h_e, t_e, d_e};
    endfunction

    task automatic model_adv(input int i);
        int it;
        case (m_ph[i])
            P_IDLE: if (start) begin m_ph[i] = P_LOAD; m_beats[i] = 0; m_halves[i] = 0; end
            P_LOAD: if (bv) begin
                if (m_beats[i] == 3) m_ph[i] = P_ISSUE;
                m_beats[i]++;
            end
            P_ISSUE: m_ph[i] = P_WAIT;
            P_WAIT: if (sdone) begin
                m_halves[i]++;
                if (m_halves[i] % 2 == 0) begin
                    it = m_halves[i] / 2;
                    if (it == maxv(i) || (ES && heq && (it - 1) >= 1)) m_ph[i] = P_FIN;
                    else m_ph[i] = P_ISSUE;
                end else begin
                    m_ph[i] = P_ISSUE;
                end
            end
            default: m_ph[i] = P_IDLE;
        endcase
    endtask

    // ---------------- per-frame counters ----------------
    logic [13:0] obs [NDUT];
    int          c_we [NDUT], c_ss [NDUT], c_dn [NDUT], it_dn [NDUT];
    logic [15:0] hs   [NDUT];
    logic        any_ss;
    int          cd    = 0;
    int          r_dly = 5;

    task automatic clr_counts();
        for (int i = 0; i < NDUT; i++) begin
            c_we[i] = 0; c_ss[i] = 0; c_dn[i] = 0; it_dn[i] = -1; hs[i] = '0;
        end
    endtask

    // One clock cycle: sample and check at the falling edge, advance model at the rising edge.
    task automatic step();
        @(negedge clk);
        if (!rst_n) model_reset();
        any_ss = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            obs[i] = {busy[i], we[i], idx[i], clr[i], ss[i], half[i], iter[i], dn[i]};
            check($sformatf("model_u%0d_cyc%0d", i, cyc), int'(obs[i]), int'(model_out(i)));
            if (we[i]) c_we[i]++;
            if (ss[i]) begin c_ss[i]++; hs[i] = {hs[i][14:0], half[i]}; any_ss = 1'b1; end
            if (dn[i]) begin c_dn[i]++; it_dn[i] = int'(iter[i]); end
        end
        @(posedge clk);
        if (rst_n) for (int i = 0; i < NDUT; i++) model_adv(i);
        #1;
        cyc++;
    endtask

    // Step plus a SISO responder answering each siso_start_o r_dly cycles later.
    task automatic rstep();
        step();
        if (any_ss) cd = r_dly;
        else if (cd > 0) cd--;
        sdone = (cd == 1);
    endtask

    function automatic bit all_done();
        return (c_dn[0] > 0) && (c_dn[1] > 0) && (c_dn[2] > 0);
    endfunction

    function automatic int exp_iter(input int i, input bit h);
        if (h && ES && maxv(i) > 2) return 2;
        return maxv(i);
    endfunction

    function automatic int exp_hs(input int it);
        int v = 0;
        for (int k = 0; k < 2 * it; k++) v = ((v << 1) | (k % 2)) & 16'hFFFF;
        return v;
    endfunction

    task automatic run_frame(input string tag, input int gap, input int dly, input bit h);
        int k;
        clr_counts();
        r_dly = dly; heq = h; cd = 0; sdone = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        for (int b = 0; b < 4; b++) begin
            bv = 1'b1; step(); bv = 1'b0;
            if (b < 3) repeat (gap) step();
        end
        for (int i = 0; i < NDUT; i++)
            check($sformatf("%s_u%0d_ss_before_4th_beat", tag, i), c_ss[i], 0);
        k = 0;
        while (k < 3000 && !all_done()) begin rstep(); k++; end
        check($sformatf("%s_timeout", tag), int'(all_done()), 1);
        rstep();
        sdone = 1'b0; heq = 1'b0; cd = 0;
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("%s_u%0d_we_count", tag, i), c_we[i], 4);
            check($sformatf("%s_u%0d_ss_count", tag, i), c_ss[i], 2 * exp_iter(i, h));
            check($sformatf("%s_u%0d_done_count", tag, i), c_dn[i], 1);
            check($sformatf("%s_u%0d_iter_at_done", tag, i), it_dn[i], exp_iter(i, h));
            check($sformatf("%s_u%0d_half_seq", tag, i), int'(hs[i]), exp_hs(exp_iter(i, h)));
        end
    endtask

    // ---------------- directed vector table (checked against the MAX_ITER=2 instance) ----------------
    typedef struct {
        logic        rst, st, v, d;
        logic [13:0] exp;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic r, input logic s, input logic v, input logic d,
                       input logic e_busy, input logic e_we, input logic [1:0] e_idx,
                       input logic e_clr, input logic e_ss, input logic e_half,
                       input logic [5:0] e_it, input logic e_dn);
        vec_t t;
        t.rst = r; t.st = s; t.v = v; t.d = d;
        t.exp = {e_busy, e_we, e_idx, e_clr, e_ss, e_half, e_it, e_dn};
        tbl.push_back(t);
    endtask

    task automatic add_pass(input logic hf, input logic [5:0] it);
        add(1, 0, 0, 0, 1, 0, 2'd0, 0, 1, hf, it, 0);                       // issue
        repeat (4) add(1, 0, 0, 0, 1, 0, 2'd0, 0, 0, hf, it, 0);            // wait
        add(1, 0, 0, 1, 1, 0, 2'd0, 0, 0, hf, it, 0);                       // completion
    endtask

    initial begin
        bit found;
        model_reset();
        clr_counts();

        // reset held with start high, then start on the first edge after release
        add(0, 1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 6'd0, 0);
        add(1, 1, 0, 0, 0, 0, 2'd0, 1, 0, 0, 6'd0, 0);
        add(1, 0, 1, 0, 1, 1, 2'd0, 0, 0, 0, 6'd0, 0);
        add(1, 1, 1, 0, 1, 1, 2'd1, 0, 0, 0, 6'd0, 0);   // start during load ignored
        add(1, 0, 1, 0, 1, 1, 2'd2, 0, 0, 0, 6'd0, 0);
        add(1, 0, 1, 0, 1, 1, 2'd3, 0, 0, 0, 6'd0, 0);
        add(1, 0, 0, 1, 1, 0, 2'd0, 0, 1, 0, 6'd0, 0);   // D1 issue, stray done ignored
        add(1, 1, 0, 0, 1, 0, 2'd0, 0, 0, 0, 6'd0, 0);   // D1 wait, start ignored
        repeat (3) add(1, 0, 0, 0, 1, 0, 2'd0, 0, 0, 0, 6'd0, 0);
        add(1, 0, 0, 1, 1, 0, 2'd0, 0, 0, 0, 6'd0, 0);   // D1 done, 5 cycles after start
        add_pass(1'b1, 6'd0);
        add_pass(1'b0, 6'd1);
        add_pass(1'b1, 6'd1);
        add(1, 0, 0, 0, 1, 0, 2'd0, 0, 0, 0, 6'd2, 1);   // finish
        add(1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 6'd2, 0);   // idle, iter held

        for (int r = 0; r < tbl.size(); r++) begin
            rst_n = tbl[r].rst; start = tbl[r].st; bv = tbl[r].v; sdone = tbl[r].d;
            step();
            check($sformatf("vec%0d", r), int'(obs[1]), int'(tbl[r].exp));
        end
        start = 0; bv = 0; sdone = 0;
        rst_n = 1'b0; step(); rst_n = 1'b1; step();

        // continuous beats, done 5 cycles after each start
        run_frame("cont", 0, 5, 1'b0);
        // beats with 2-cycle gaps
        run_frame("gap2", 2, 3, 1'b0);

        // reset while the MAX_ITER=2 instance sits in D2 wait at iter 1
        clr_counts();
        r_dly = 5; cd = 0;
        start = 1'b1; step(); start = 1'b0;
        bv = 1'b1; repeat (4) step(); bv = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            rstep();
            if (busy[1] && half[1] && !ss[1] && iter[1] == 6'd1) found = 1'b1;
        end
        check("d2wait_iter1_reached", int'(found), 1);
        rst_n = 1'b0; sdone = 1'b0; cd = 0;
        step();
        check("midreset_busy", int'(obs[1][13]), 0);
        check("midreset_half", int'(obs[1][7]), 0);
        check("midreset_iter", int'(obs[1][6:1]), 0);
        rst_n = 1'b1;
        run_frame("after_reset", 0, 5, 1'b0);

        // hard decisions converged throughout
        run_frame("hard_eq", 0, 2, 1'b1);

        // randomized traffic including stray pulses and occasional resets
        for (int k = 0; k < 2500; k++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            start = ($urandom_range(0, 7) == 0);
            bv    = 1'($urandom_range(0, 1));
            sdone = ($urandom_range(0, 3) == 0);
            heq   = 1'($urandom_range(0, 1));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_turbo_iter_ctrl

// File: doc/turbo_iter_ctrl.md
TURBO_ITER_CTRL -- requirements
Module: turbo_iter_ctrl

Interface
REQ-001 SHALL have parameter MAX_ITER, default 8, full turbo iterations per frame (1..63).
REQ-002 SHALL have parameter BLK_BEATS, default 4, input beats per frame (1..4).
REQ-003 SHALL have port clk_p_i  in  1  single clock, all state changes on its rising edge.
REQ-004 SHALL have port reset_n_i  in  1  asynchronous active-low reset.
REQ-005 SHALL have port start_i  in  1  frame start request, sampled in IDLE only.
REQ-006 SHALL have port beat_valid_i  in  1  one input beat available to load.
REQ-007 SHALL have port load_we_o  out  1  write enable to systematic/parity buffers.
REQ-008 SHALL have port load_idx_o  out  2  beat index for the current write.
REQ-009 SHALL have port ext_clr_o  out  1  clear extrinsic store, one-cycle pulse.
REQ-010 SHALL have port siso_start_o  out  1  SISO read-enable, one-cycle pulse.
REQ-011 SHALL have port siso_done_i  in  1  SISO completion pulse.
REQ-012 SHALL have port half_o  out  1  0 = DEC1 (natural order, parity 1), 1 = DEC2 (interleaved, parity 2).
REQ-013 SHALL have port iter_o  out  6  completed full iterations.
REQ-014 SHALL have port hard_eq_i  in  1  hard decisions unchanged since the previous DEC2.
REQ-015 SHALL have port busy_o  out  1  high in every state except IDLE.
REQ-016 SHALL have port done_o  out  1  frame finished, one-cycle pulse.

Function
REQ-017 SHALL implement states IDLE, LOAD, D1_ISSUE, D1_WAIT, D2_ISSUE, D2_WAIT, FINISH.
REQ-018 SHALL go IDLE->LOAD when start_i=1; ext_clr_o=1 in that IDLE cycle; iter_o and the beat count cleared to 0.
REQ-019 SHALL drive load_we_o = beat_valid_i AND state==LOAD (combinational), with load_idx_o = beat count; the count increments per accepted beat.
REQ-020 SHALL go LOAD->D1_ISSUE on the cycle the beat at index BLK_BEATS-1 is accepted; gaps in beat_valid_i stall LOAD indefinitely.
REQ-021 SHALL assert siso_start_o for exactly the single cycle spent in D1_ISSUE or D2_ISSUE, then move to the matching WAIT state.
REQ-022 SHALL drive half_o=0 in D1_* states and 1 in D2_*; half_o is stable for the whole WAIT so the datapath selects its operands from it.
REQ-023 SHALL go D1_WAIT->D2_ISSUE on siso_done_i=1.
REQ-024 SHALL, on siso_done_i=1 in D2_WAIT, increment iter_o, then go to FINISH if the new count equals MAX_ITER, else to D1_ISSUE.
REQ-025 SHALL ignore siso_done_i in all states other than D1_WAIT and D2_WAIT, including ISSUE cycles.
REQ-026 SHALL ignore start_i while busy; no restart mid-frame.
REQ-027 SHALL pulse done_o in FINISH for one cycle, then return to IDLE; iter_o holds its value until the next start.
REQ-028 SHALL give minimum latency start_i -> first siso_start_o of 1+BLK_BEATS cycles with continuous beats.

Reset
REQ-029 SHALL, while reset_n_i=0, force state IDLE, iter_o=0, beat count 0, and all pulse outputs, busy_o and half_o to 0, including when reset is asserted mid-frame.
REQ-030 SHALL accept start_i on the first rising edge after reset deasserts.

Configuration
REQ-031 SHALL, with EARLY_STOP_EN defined, go D2_WAIT->FINISH on siso_done_i=1 AND hard_eq_i=1 when iter_o>=1 before the increment, still incrementing iter_o.
REQ-032 SHALL, without EARLY_STOP_EN, ignore hard_eq_i; the port remains present.

Structure
REQ-033 SHALL take the state encoding and the default values of MAX_ITER and BLK_BEATS from the shared decoder package.
REQ-034 SHALL be a single module with no sub-module; the iteration counter stays inline.

Verification
REQ-035 SHALL cover: MAX_ITER=2, BLK_BEATS=4, continuous beats, siso_done_i 5 cycles after each start -> load_idx_o 0..3, 4 siso_start_o pulses with half_o 0,1,0,1, then done_o with iter_o=2.
REQ-036 SHALL cover: beat_valid_i with 2-cycle gaps -> exactly 4 load_we_o pulses, and no siso_start_o before the 4th beat.
REQ-037 SHALL cover: start_i and stray siso_done_i pulses during D1_WAIT and D1_ISSUE -> start_i ignored, the ISSUE-cycle done ignored, sequence otherwise unchanged.
REQ-038 SHALL cover: reset_n_i low during D2_WAIT at iter_o=1 -> immediate IDLE, iter_o=0; a new start completes normally.
REQ-039 SHALL cover: EARLY_STOP_EN defined, MAX_ITER=8, hard_eq_i=1 from iteration 2 -> done_o with iter_o=2; without the macro -> iter_o=8.
REQ-040 SHALL cover: MAX_ITER=1 -> exactly 2 siso_start_o pulses, then done_o.
